// File: rtl/line_mem_scheduler_pkg.sv
// Shared cache-line types for the line memory scheduler.
// Holds the owner and scheduler state enums, the line-address mask,
// and the packed descriptor of a granted request.
package line_mem_scheduler_pkg;

  localparam int unsigned ADDR_BITS        = 32;
  localparam int unsigned DEF_LINE_BITS    = 256;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned OFFSET_BITS      = 5;

  // Clears the byte-offset bits of a line address.
  localparam logic [ADDR_BITS-1:0] LINE_ADDR_MASK =
    ~ADDR_BITS'((32'd1 << OFFSET_BITS) - 32'd1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2,
    OWN_P    = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request chosen by arbitration in the current IDLE cycle.
  typedef struct packed {
    owner_e                 owner;
    logic                   write;
    logic [ADDR_BITS-1:0]   addr;
  } sched_req_t;

  function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] addr);
    return addr & LINE_ADDR_MASK;
  endfunction

endpackage

// File: rtl/line_sched_prio.sv
// Combinational requester picker: dcache > icache > prefetch, except that
// icache wins outright once the starve counter has saturated.
// Ports: starved (counter at limit), dc_req/ic_req/pf_req (request levels),
//        owner_c (chosen owner, OWN_NONE when nobody requests).
module line_sched_prio
  import line_mem_scheduler_pkg::*;
(
  input  logic   starved,
  input  logic   dc_req,
  input  logic   ic_req,
  input  logic   pf_req,
  output owner_e owner_c
);

  always_comb begin
    owner_c = OWN_NONE;
    if (starved && ic_req) begin
      owner_c = OWN_I;
    end else if (dc_req) begin
      owner_c = OWN_D;
    end else if (ic_req) begin
      owner_c = OWN_I;
    end else if (pf_req) begin
      owner_c = OWN_P;
    end
  end

endmodule

// File: rtl/line_mem_scheduler.sv
// Shares one cacheline adaptor among dcache, icache and the prefetcher.
// A granted request is latched, driven to memory until mem_resp, and
// answered with a registered one-cycle *_resp plus held *_rdata.
// Ports: clk/rst (sync, active high); dc_*/ic_*/pf_* requester side;
//        mem_* adaptor side; busy high whenever a transaction is open.
module line_mem_scheduler
  import line_mem_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned LINE_BITS    = DEF_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dc_addr,
  input  logic                 dc_read,
  input  logic                 dc_write,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic [LINE_BITS-1:0] dc_rdata,
  output logic                 dc_resp,
  input  logic [31:0]          ic_addr,
  input  logic                 ic_read,
  output logic [LINE_BITS-1:0] ic_rdata,
  output logic                 ic_resp,
  input  logic [31:0]          pf_addr,
  input  logic                 pf_read,
  output logic [LINE_BITS-1:0] pf_rdata,
  output logic                 pf_resp,
  output logic [31:0]          mem_addr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_resp,
  output logic                 busy
);

  localparam int unsigned CNT_BITS = $clog2(STARVE_LIMIT + 1);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic [CNT_BITS-1:0]  starve_q, starve_d;
  owner_e               grant_c;
  sched_req_t           req_c;
  logic [31:0]          mem_addr_d;
  logic                 mem_read_d, mem_write_d;
  logic [LINE_BITS-1:0] mem_wdata_d;
  logic [2:0]           resp_d;   // [0]=dcache, [1]=icache, [2]=prefetch

  line_sched_prio u_prio (
    .starved (starve_q == CNT_BITS'(STARVE_LIMIT)),
    .dc_req  (dc_read | dc_write),
    .ic_req  (ic_read),
    .pf_req  (pf_read),
    .owner_c (grant_c)
  );

  // Granted request descriptor; a write wins over a read on dcache.
  always_comb begin
    req_c       = '0;
    req_c.owner = grant_c;
    req_c.write = (grant_c == OWN_D) && dc_write;
    unique case (grant_c)
      OWN_D:   req_c.addr = line_align(dc_addr);
      OWN_I:   req_c.addr = line_align(ic_addr);
      OWN_P:   req_c.addr = line_align(pf_addr);
      default: req_c.addr = '0;
    endcase
  end

  // Next state, starve counter and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr;
    mem_read_d  = mem_read;
    mem_write_d = mem_write;
    mem_wdata_d = mem_wdata;
    resp_d      = '0;
    unique case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (req_c.owner != OWN_NONE) begin
          state_d     = XFER;
          owner_d     = req_c.owner;
          mem_addr_d  = req_c.addr;
          mem_read_d  = !req_c.write;
          mem_write_d = req_c.write;
          if (req_c.write) begin
            mem_wdata_d = dc_wdata;
          end
        end
        if (!ic_read || req_c.owner == OWN_I) begin
          starve_d = '0;
        end else if (req_c.owner == OWN_D && starve_q != CNT_BITS'(STARVE_LIMIT)) begin
          starve_d = starve_q + CNT_BITS'(1);
        end
      end
      XFER: begin
        if (mem_resp) begin
          state_d     = RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          unique case (owner_q)
            OWN_D:   resp_d = 3'b001;
            OWN_I:   resp_d = 3'b010;
            OWN_P:   resp_d = 3'b100;
            default: resp_d = 3'b000;
          endcase
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; rdata captured on the response edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      starve_q  <= '0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      dc_rdata  <= '0;
      ic_rdata  <= '0;
      pf_rdata  <= '0;
      dc_resp   <= 1'b0;
      ic_resp   <= 1'b0;
      pf_resp   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      mem_addr  <= mem_addr_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      mem_wdata <= mem_wdata_d;
      dc_resp   <= resp_d[0];
      ic_resp   <= resp_d[1];
      pf_resp   <= resp_d[2];
      busy      <= (state_d != IDLE);
      if (resp_d[0]) dc_rdata <= mem_rdata;
      if (resp_d[1]) ic_rdata <= mem_rdata;
      if (resp_d[2]) pf_rdata <= mem_rdata;
    end
  end

  // dcache must never ask for a read and a writeback at once.
  a_dc_dir_excl: assert property (@(posedge clk) disable iff (rst) !(dc_read && dc_write));

endmodule

// File: tb/tb_line_mem_scheduler.sv
// Bench for line_mem_scheduler: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-rule model.
module tb_line_mem_scheduler;

  localparam int unsigned LB    = 256;
  localparam int          LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   dc_addr, ic_addr, pf_addr;
  logic          dc_read, dc_write, ic_read, pf_read;
  logic [LB-1:0] dc_wdata, mem_rdata;
  logic          mem_resp;
  logic [LB-1:0] dc_rdata, ic_rdata, pf_rdata, mem_wdata;
  logic          dc_resp, ic_resp, pf_resp, mem_read, mem_write, busy;
  logic [31:0]   mem_addr;

  always #5 clk = ~clk;

  line_mem_scheduler #(.STARVE_LIMIT(LIMIT), .LINE_BITS(LB)) dut (
    .clk(clk), .rst(rst),
    .dc_addr(dc_addr), .dc_read(dc_read), .dc_write(dc_write), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .ic_addr(ic_addr), .ic_read(ic_read), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
    .pf_addr(pf_addr), .pf_read(pf_read), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
  );

  // Reference model: m_phase 0 = waiting to grant, 1 = memory transfer, 2 = answer cycle.
  int            m_phase = 0;
  int            m_owner = 0;     // 1 dcache, 2 icache, 3 prefetch
  int            starve  = 0;
  logic          e_mem_read = 1'b0, e_mem_write = 1'b0, e_busy = 1'b0;
  logic [31:0]   e_mem_addr = '0;
  logic [LB-1:0] e_mem_wdata = '0;
  logic [2:0]    e_resp = '0;
  logic [LB-1:0] e_rdata [3];

  // Adaptor model.
  int            lat_next = 4;
  int            lat_cnt  = 0;
  bit            adapt_on = 1'b0;
  logic [LB-1:0] data_next = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int resp_log[$];

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] v;
    v = '0;
    for (int k = 0; k < int'(LB / 32); k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the adaptor, compare this cycle, advance the model, move to next negedge.
  task automatic tick();
    int          g;
    bit          wr;
    logic [31:0] a;
    if (!rst && (e_mem_read || e_mem_write)) begin
      if (!adapt_on) begin
        adapt_on = 1'b1;
        lat_cnt  = lat_next;
      end
      lat_cnt--;
      mem_resp = (lat_cnt == 0);
      if (mem_resp) begin
        mem_rdata = data_next;
        adapt_on  = 1'b0;
      end
    end else begin
      mem_resp = 1'b0;
      adapt_on = 1'b0;
    end

    check("dc_resp", dc_resp, e_resp[0]);
    check("ic_resp", ic_resp, e_resp[1]);
    check("pf_resp", pf_resp, e_resp[2]);
    check("dc_rdata", dc_rdata, e_rdata[0]);
    check("ic_rdata", ic_rdata, e_rdata[1]);
    check("pf_rdata", pf_rdata, e_rdata[2]);
    check("mem_read", mem_read, e_mem_read);
    check("mem_write", mem_write, e_mem_write);
    check("mem_addr", mem_addr, e_mem_addr);
    check("mem_wdata", mem_wdata, e_mem_wdata);
    check("busy", busy, e_busy);
    if (dc_resp === 1'b1) resp_log.push_back(1);
    if (ic_resp === 1'b1) resp_log.push_back(2);
    if (pf_resp === 1'b1) resp_log.push_back(3);

    if (rst) begin
      m_phase = 0; m_owner = 0; starve = 0;
      e_mem_read = 1'b0; e_mem_write = 1'b0; e_busy = 1'b0;
      e_mem_addr = '0; e_mem_wdata = '0; e_resp = '0;
      for (int k = 0; k < 3; k++) e_rdata[k] = '0;
    end else begin
      e_resp = '0;
      if (m_phase == 0) begin
        g = 0;
        if (starve == LIMIT && ic_read) g = 2;
        else if (dc_read || dc_write)   g = 1;
        else if (ic_read)               g = 2;
        else if (pf_read)               g = 3;
        if (g == 2 || !ic_read) starve = 0;
        else if (g == 1 && starve < LIMIT) starve++;
        if (g != 0) begin
          wr = (g == 1) && dc_write;
          a  = (g == 1) ? dc_addr : (g == 2) ? ic_addr : pf_addr;
          m_owner     = g;
          m_phase     = 1;
          e_busy      = 1'b1;
          e_mem_read  = !wr;
          e_mem_write = wr;
          e_mem_addr  = a - (a % 32'd32);
          if (wr) e_mem_wdata = dc_wdata;
        end
      end else if (m_phase == 1) begin
        if (mem_resp) begin
          e_rdata[m_owner-1] = mem_rdata;
          e_resp[m_owner-1]  = 1'b1;
          e_mem_read  = 1'b0;
          e_mem_write = 1'b0;
          m_phase     = 2;
        end
      end else begin
        m_phase = 0;
        m_owner = 0;
        e_busy  = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Random requesters: level requests, occasional withdrawal, never read+write together.
  task automatic drive_random();
    bit wr;
    if (e_resp[0]) begin dc_read = 1'b0; dc_write = 1'b0; end
    if (e_resp[1]) ic_read = 1'b0;
    if (e_resp[2]) pf_read = 1'b0;
    if (dc_read || dc_write) begin
      if ($urandom_range(0, 19) == 0) begin dc_read = 1'b0; dc_write = 1'b0; end
    end else if (!(m_phase == 1 && m_owner == 1) && $urandom_range(0, 99) < 30) begin
      wr = 1'($urandom_range(0, 1));
      dc_read = !wr; dc_write = wr; dc_addr = $urandom; dc_wdata = rand_line();
    end
    if (ic_read) begin
      if ($urandom_range(0, 19) == 0) ic_read = 1'b0;
    end else if (!(m_phase == 1 && m_owner == 2) && $urandom_range(0, 99) < 25) begin
      ic_read = 1'b1; ic_addr = $urandom;
    end
    if (pf_read) begin
      if ($urandom_range(0, 19) == 0) pf_read = 1'b0;
    end else if (!(m_phase == 1 && m_owner == 3) && $urandom_range(0, 99) < 20) begin
      pf_read = 1'b1; pf_addr = $urandom;
    end
    if (!adapt_on) begin
      lat_next  = $urandom_range(1, 8);
      data_next = rand_line();
    end
  endtask

  initial begin
    int            cnt;
    int            seen;
    int            got;
    logic [LB-1:0] wd;
    int            exp_order[6];

    for (int k = 0; k < 3; k++) e_rdata[k] = '0;
    rst = 1'b1;
    dc_addr = '0; ic_addr = '0; pf_addr = '0;
    dc_read = 1'b0; dc_write = 1'b0; ic_read = 1'b0; pf_read = 1'b0;
    dc_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Lone dcache read, adaptor latency 10, pattern 0xAA.
    resp_log.delete();
    dc_read = 1'b1; dc_addr = 32'h0000_1234;
    lat_next = 10; data_next = {(LB/8){8'hAA}};
    cnt = 0; seen = 0;
    for (int c = 0; c < 40 && dc_resp !== 1'b1; c++) begin
      if (mem_read === 1'b1) begin
        cnt++;
        if (seen == 0) check("t1_addr", mem_addr, 32'h0000_1220);
        seen = 1;
      end
      tick();
    end
    check("t1_resp", dc_resp, 1'b1);
    check("t1_strobe_cycles", cnt, 10);
    check("t1_rdata", dc_rdata, {(LB/8){8'hAA}});
    dc_read = 1'b0;
    tick(); tick();

    // dcache and icache together: dcache first, icache next.
    resp_log.delete();
    dc_read = 1'b1; dc_addr = 32'h0000_4444;
    ic_read = 1'b1; ic_addr = 32'h0000_8888;
    lat_next = 3; data_next = rand_line();
    for (int c = 0; c < 60 && resp_log.size() < 2; c++) begin
      if (dc_resp === 1'b1) begin dc_read = 1'b0; data_next = rand_line(); end
      if (ic_resp === 1'b1) ic_read = 1'b0;
      tick();
    end
    got = resp_log.size();
    check("t2_count", got, 2);
    check("t2_first", (got > 0) ? resp_log[0] : 0, 1);
    check("t2_second", (got > 1) ? resp_log[1] : 0, 2);
    tick(); tick();

    // Continuous dcache traffic with icache held: starvation override after 4.
    resp_log.delete();
    exp_order = '{1, 1, 1, 1, 2, 1};
    dc_read = 1'b1; dc_addr = 32'h0001_0000;
    ic_read = 1'b1; ic_addr = 32'h0002_0040;
    lat_next = 2;
    for (int c = 0; c < 400 && resp_log.size() < 6; c++) begin
      if (ic_resp === 1'b1) ic_read = 1'b0;
      if (dc_resp === 1'b1) begin
        dc_addr = $urandom;
        if (resp_log.size() >= 5) dc_read = 1'b0;
      end
      data_next = rand_line();
      tick();
    end
    got = resp_log.size();
    check("t3_count", got, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_order%0d", i), (i < got) ? resp_log[i] : 0, exp_order[i]);
    dc_read = 1'b0; ic_read = 1'b0;
    tick(); tick();

    // Prefetch in flight, dcache writeback arrives mid-transfer and waits.
    resp_log.delete();
    pf_read = 1'b1; pf_addr = 32'h0003_007F;
    lat_next = 6; data_next = rand_line();
    wd = rand_line();
    seen = 0;
    for (int c = 0; c < 80 && resp_log.size() < 2; c++) begin
      if (c == 3) begin dc_write = 1'b1; dc_addr = 32'h0004_0105; dc_wdata = wd; end
      if (pf_resp === 1'b1) begin pf_read = 1'b0; data_next = rand_line(); end
      if (dc_resp === 1'b1) dc_write = 1'b0;
      if (mem_write === 1'b1 && seen == 0) begin
        check("t4_wdata", mem_wdata, wd);
        check("t4_waddr", mem_addr, 32'h0004_0100);
        seen = 1;
      end
      tick();
    end
    got = resp_log.size();
    check("t4_write_seen", seen, 1);
    check("t4_first", (got > 0) ? resp_log[0] : 0, 3);
    check("t4_second", (got > 1) ? resp_log[1] : 0, 1);
    dc_write = 1'b0;
    tick(); tick();

    // Reset three cycles into an icache transfer: abandoned, no response.
    resp_log.delete();
    ic_read = 1'b1; ic_addr = 32'h0005_0020;
    lat_next = 20; data_next = rand_line();
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1; ic_read = 1'b0;
    tick();
    rst = 1'b0;
    check("t5_mem_read", mem_read, 1'b0);
    check("t5_busy", busy, 1'b0);
    for (int c = 0; c < 30; c++) tick();
    check("t5_no_resp", resp_log.size(), 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      tick();
    end
    dc_read = 1'b0; dc_write = 1'b0; ic_read = 1'b0; pf_read = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    check("end_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
